// File: rtl/life_controller.sv
// life_controller: frog lives / death-hold / invulnerability sequencer.
// Tracks remaining lives, sequences the death hold and post-respawn
// invulnerability window, and blinks the heart HUD while invulnerable.
// Optional feature macro: EXTRA_LIFE_EN (bonus pulses award a life,
// saturating at 3). With the macro undefined the bonus port is ignored.
module life_controller #(
  parameter logic [1:0] START_LIVES   = 2'd3,
  parameter int         DEATH_FRAMES  = 60,
  parameter int         INVULN_FRAMES = 120,
  parameter int         BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       new_game,
  input  logic       bonus,
  output logic [1:0] lives,
  output logic       hud_visible,
  output logic       invulnerable,
  output logic       respawn,
  output logic       game_over
);

  localparam logic [1:0] ST_PLAY      = 2'd0;
  localparam logic [1:0] ST_DYING     = 2'd1;
  localparam logic [1:0] ST_INVULN    = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  // One shared frame counter serves both timed states, so it is sized
  // for the longer of the two windows.
  localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
  localparam int BLK_W      = $clog2(BLINK_FRAMES + 1);

  localparam logic [CNT_W-1:0] DEATH_LAST  = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST  = BLK_W'(BLINK_FRAMES - 1);

`ifdef EXTRA_LIFE_EN
  localparam logic EXTRA_EN = 1'b1;
`else
  localparam logic EXTRA_EN = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             hud_q, hud_d;
  logic             inv_q, inv_d;
  logic             respawn_q, respawn_d;
  logic             over_q, over_d;
  logic             bonus_en;

  // Lives never wrap past the three-heart HUD.
  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  assign bonus_en = bonus & EXTRA_EN;

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    hud_d       = hud_q;
    inv_d       = inv_q;
    respawn_d   = 1'b0;
    over_d      = over_q;

    if (new_game) begin
      // Restart wins over hit and bonus; the frog respawns invulnerable.
      state_d     = ST_INVULN;
      lives_d     = START_LIVES;
      frame_cnt_d = '0;
      blink_cnt_d = '0;
      hud_d       = 1'b1;
      inv_d       = 1'b1;
      respawn_d   = 1'b1;
      over_d      = 1'b0;
    end else begin
      case (state_q)
        ST_PLAY: begin
          if (hit) begin
            if (bonus_en || lives_q > 2'd1) begin
              // A coincident bonus cancels the lost life.
              lives_d     = bonus_en ? lives_q : lives_q - 2'd1;
              state_d     = ST_DYING;
              frame_cnt_d = '0;
              inv_d       = 1'b1;
            end else begin
              lives_d = 2'd0;
              state_d = ST_GAME_OVER;
              over_d  = 1'b1;
            end
          end else if (bonus_en) begin
            lives_d = sat_inc(lives_q);
          end
        end
        ST_DYING: begin
          if (bonus_en) lives_d = sat_inc(lives_q);
          if (frame_tick) begin
            if (frame_cnt_q == DEATH_LAST) begin
              state_d     = ST_INVULN;
              frame_cnt_d = '0;
              blink_cnt_d = '0;
              hud_d       = 1'b1;
              respawn_d   = 1'b1;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
            end
          end
        end
        ST_INVULN: begin
          if (bonus_en) lives_d = sat_inc(lives_q);
          if (frame_tick) begin
            if (frame_cnt_q == INVULN_LAST) begin
              state_d     = ST_PLAY;
              frame_cnt_d = '0;
              blink_cnt_d = '0;
              hud_d       = 1'b1;
              inv_d       = 1'b0;
            end else begin
              frame_cnt_d = frame_cnt_q + 1'b1;
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                hud_d       = ~hud_q;
              end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
              end
            end
          end
        end
        default: begin
          // Game over: hold until new_game.
        end
      endcase
    end
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLAY;
      lives_q     <= START_LIVES;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
      hud_q       <= 1'b1;
      inv_q       <= 1'b0;
      respawn_q   <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      hud_q       <= hud_d;
      inv_q       <= inv_d;
      respawn_q   <= respawn_d;
      over_q      <= over_d;
    end
  end

  assign lives        = lives_q;
  assign hud_visible  = hud_q;
  assign invulnerable = inv_q;
  assign respawn      = respawn_q;
  assign game_over    = over_q;

endmodule

// File: tb/tb_life_controller.sv
// Testbench for life_controller with short death/invulnerability windows.
module tb_life_controller;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic       hit;
  logic       new_game;
  logic       bonus;
  logic [1:0] lives;
  logic       hud_visible;
  logic       invulnerable;
  logic       respawn;
  logic       game_over;

  int n_tests = 0;
  int n_fail  = 0;

  life_controller #(
    .START_LIVES  (2'd3),
    .DEATH_FRAMES (4),
    .INVULN_FRAMES(16),
    .BLINK_FRAMES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .hit         (hit),
    .new_game    (new_game),
    .bonus       (bonus),
    .lives       (lives),
    .hud_visible (hud_visible),
    .invulnerable(invulnerable),
    .respawn     (respawn),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic       ng;
    logic       bonus;
    logic       tick;
    logic [1:0] lives;
    logic       hud;
    logic       inv;
    logic       resp;
    logic       go;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic h, input logic n, input logic b, input logic t,
                              input logic [1:0] l, input logic hv, input logic iv,
                              input logic rp, input logic g);
    vec_t v;
    v.hit = h; v.ng = n; v.bonus = b; v.tick = t;
    v.lives = l; v.hud = hv; v.inv = iv; v.resp = rp; v.go = g;
    return v;
  endfunction

  task automatic chk(input string name, input logic [1:0] l, input logic hv,
                     input logic iv, input logic rp, input logic g);
    logic [5:0] act, exp;
    act = {lives, hud_visible, invulnerable, respawn, game_over};
    exp = {l, hv, iv, rp, g};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lives=%0d hud=%b inv=%b resp=%b go=%b, want lives=%0d hud=%b inv=%b resp=%b go=%b",
               name, act[5:4], act[3], act[2], act[1], act[0], l, hv, iv, rp, g);
    end
  endtask

  // Drive one cycle of inputs; returns #1 after the sampling edge.
  task automatic step(input logic h, input logic n, input logic b, input logic t);
    hit = h; new_game = n; bonus = b; frame_tick = t;
    @(posedge clk);
    #1;
    hit = 1'b0; new_game = 1'b0; bonus = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    hit = 1'b0; new_game = 1'b0; bonus = 1'b0; frame_tick = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Hit in PLAY then sit out the full death hold and invulnerability.
  task automatic hit_and_recover();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(4 + 16);
  endtask

  logic [1:0] exp_l;

  initial begin
    rst_n = 1'b0;
    hit = 1'b0; new_game = 1'b0; bonus = 1'b0; frame_tick = 1'b0;

    // Main scenario: hit, death hold, blinking invulnerability, back to play.
    vecs.push_back(mk(0,0,0,0, 2'd3,1,0,0,0));
    vecs.push_back(mk(1,0,0,1, 2'd2,1,1,0,0));
    vecs.push_back(mk(0,0,0,1, 2'd2,1,1,0,0));
    vecs.push_back(mk(1,0,0,0, 2'd2,1,1,0,0));
    vecs.push_back(mk(0,0,0,1, 2'd2,1,1,0,0));
    vecs.push_back(mk(0,0,0,1, 2'd2,1,1,0,0));
    vecs.push_back(mk(0,0,0,1, 2'd2,1,1,1,0));
    vecs.push_back(mk(0,0,0,0, 2'd2,1,1,0,0));
    for (int i = 1; i <= 16; i++) begin
      logic hv;
      hv = (i < 4) ? 1'b1 : (i < 8) ? 1'b0 : (i < 12) ? 1'b1 : (i < 16) ? 1'b0 : 1'b1;
      vecs.push_back(mk((i == 5 || i == 10), 0, 0, 1, 2'd2, hv, (i < 16), 0, 0));
    end
    vecs.push_back(mk(0,0,0,0, 2'd2,1,0,0,0));
    vecs.push_back(mk(1,0,0,0, 2'd1,1,1,0,0));

    // Reset state, sampled while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].hit, vecs[k].ng, vecs[k].bonus, vecs[k].tick);
      chk($sformatf("vec%0d", k), vecs[k].lives, vecs[k].hud, vecs[k].inv,
          vecs[k].resp, vecs[k].go);
    end

    // Three hits with recovery -> game over; hit ignored; new_game restarts.
    do_reset();
    hit_and_recover();
    chk("go_after1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    hit_and_recover();
    chk("go_after2", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("go_enter", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("go_hit_ignored", 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("go_new_game", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("go_respawn_one_cycle", 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);

    // hit and new_game together at lives==1: new_game wins.
    ticks(16);
    chk("ng_back_to_play", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    hit_and_recover();
    hit_and_recover();
    chk("prio_lives1", 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("prio_hit_newgame", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset mid-DYING aborts with no respawn; async, no clock edge needed.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("abort_pre", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ticks(2);
    chk("abort_no_respawn", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Bonus behaviour (depends on the build option).
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("bonus_at3", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("bonus_hit", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef EXTRA_LIFE_EN
    exp_l = 2'd3;
`else
    exp_l = 2'd2;
`endif
    chk("bonus_at2_dying", exp_l, 1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef EXTRA_LIFE_EN
    exp_l = 2'd3;
`else
    exp_l = 2'd2;
`endif
    chk("bonus_with_hit", exp_l, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
